// File: rtl/bridge_sync_fifo.sv
// Parametrised single-clock FIFO for the AXI-side datapath of the bridge.
// Occupancy, thresholds, registered/FWFT read and sticky error flags.
module bridge_sync_fifo #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] AF_TH = CW'(AFULL_TH);
  localparam logic [CW-1:0] AE_TH = CW'(AEMPTY_TH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [CW-1:0]    cnt;
  logic             wr_acc;
  logic             rd_acc;
  logic             ovf;
  logic             unf;

  // MSB is the wrap bit: same address, different lap means full
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
               && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty = (wr_ptr == rd_ptr);

  assign count        = cnt;
  assign almost_full  = (cnt >= AF_TH);
  assign almost_empty = (cnt <= AE_TH);
  assign overflow     = ovf;
  assign underflow    = unf;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // a new error in the clearing cycle keeps the flag set
      if (wr_en && full)  ovf <= 1'b1;
      else if (err_clr)   ovf <= 1'b0;
      if (rd_en && empty) unf <= 1'b1;
      else if (err_clr)   unf <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
      assign rd_valid = ~empty;
    end else begin : g_reg
      logic [WIDTH-1:0] data_q;
      logic             valid_q;

      always_ff @(posedge aclk) begin
        if (!aresetn) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_acc;
          if (rd_acc) data_q <= mem[rd_ptr[AW-1:0]];
        end
      end

      assign rd_data  = data_q;
      assign rd_valid = valid_q;
    end
  endgenerate

endmodule

// File: doc/bridge_sync_fifo.md
Name: bridge_sync_fifo

Overview:
Parametrised single-clock FIFO for the AXI-side datapath of the AXI2AHB bridge. It replaces the fixed-width per-field FIFOs with one generic buffer that sets width and depth through parameters. It adds occupancy count, programmable almost-full/almost-empty thresholds, a selectable read mode (registered or first-word-fall-through), and sticky overflow/underflow error flags. Instances sit between the AXI slave front-end and the request packer, all within one clock domain.

Parameters:
WIDTH, 64, data width in bits (1..256)
DEPTH, 16, number of entries; power of two, 2..1024
AFULL_TH, 12, almost_full asserts when count >= AFULL_TH (1..DEPTH)
AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH (0..DEPTH-1)
FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through

Ports:
aclk  in  1  clock, rising edge
aresetn  in  1  synchronous active-low reset
wr_en  in  1  write request
wr_data  in  WIDTH  write data
rd_en  in  1  read/pop request
rd_data  out  WIDTH  read data
rd_valid  out  1  rd_data holds valid data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AFULL_TH
almost_empty  out  1  count <= AEMPTY_TH
count  out  clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
err_clr  in  1  clears overflow/underflow

Behaviour:
- Reset is sampled on the aclk edge with aresetn==0. On reset: wr_ptr=rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. Memory contents are don't-care.
- Pointers are clog2(DEPTH)+1 bits; the MSB is the wrap bit. full = (addr bits equal and MSBs differ); empty = (pointers equal). Pointers wrap naturally at 2*DEPTH.
- All status outputs are registered or derived from registered count. They reflect the state after the last edge, with no same-cycle combinational path from wr_en/rd_en.
- Write is accepted iff wr_en && !full. mem[wr_ptr] <= wr_data, and wr_ptr increments.
- Read is accepted iff rd_en && !empty, and rd_ptr increments.
- A write while full is dropped. A write while full is blocked even if a read is accepted in the same cycle.
- A read while empty is ignored, even if a write is accepted in the same cycle.
- count next value: +1 on write only, -1 on read only, unchanged on both or neither.
- Registered-read mode (FWFT=0):
  - On an accepted read, rd_data <= mem[rd_ptr] and rd_valid=1 on the next cycle.
  - rd_valid=0 in any cycle following a non-accepted read.
  - rd_data holds its last value when no read is accepted.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr] whenever !empty; rd_valid = !empty.
  - rd_en acts as pop/acknowledge.
  - A word written to an empty FIFO appears on rd_data one cycle after the write edge.
- overflow is set on wr_en && full. underflow is set on rd_en && empty.
- Both flags are cleared by err_clr. If set and clear coincide in the same cycle, set wins.
- The FIFO does not flag data loss beyond overflow. Upstream logic must honour full.

Test Plan:
- Reset then idle: empty=1, almost_empty=1, count=0, rd_valid=0, all flags 0; hold aresetn low for 3 cycles mid-fill and confirm the same values.
- DEPTH=16, FWFT=0: write 0x0..0xF over 16 cycles -> full=1, count=16, almost_full from 12th write. Read 16 -> data 0x0..0xF in order, each one cycle after rd_en; empty=1 at end.
- Simultaneous rd_en and wr_en at count=5 -> count stays 5, data order preserved. At full: write dropped, overflow=1, read still accepted, count=15. At empty: read ignored, underflow=1, write accepted, count=1.
- FWFT=1: write 0xA5 into empty FIFO -> rd_data=0xA5, rd_valid=1 next cycle with no rd_en. Pop -> rd_valid=0.
- Wrap-around: 40 interleaved write/read pairs with random gaps on DEPTH=16 -> scoreboard match, count never exceeds 16, full/empty correct across pointer wrap.
- err_clr asserted in the same cycle as an overflowing write -> overflow stays 1. err_clr alone on the next cycle -> 0.
